// File: rtl/spi_ctrl_master_if.sv
// -----------------------------------------------------------------------------
// spi_ctrl_master_if
//   Bundles the request handshake, status flags, SPI pins and FSM debug
//   state of spi_ctrl_master.
//
//   Handshake: the requester drives req_valid together with stable
//   req_addr/req_data. A request transfers on a rising clk edge on which
//   req_valid && req_ready are both high. req_ready never depends
//   combinationally on req_valid. After a transfer the requester may present
//   the next request on the same cycle.
//
//   Modports:
//     master : the SPI controller (consumes requests, drives SPI pins)
//     slave  : the requester / observer side
// -----------------------------------------------------------------------------
interface spi_ctrl_master_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [2:0] fsm_state;

  modport master (
    input  req_valid, req_addr, req_data,
    output req_ready, busy, done, sclk, copi, ncs, fsm_state
  );

  modport slave (
    output req_valid, req_addr, req_data,
    input  req_ready, busy, done, sclk, copi, ncs, fsm_state
  );
endinterface

// File: rtl/spi_ctrl_master.sv
// -----------------------------------------------------------------------------
// spi_ctrl_master
//   Write-only SPI mode-0 controller. Each accepted request becomes one
//   16-bit frame {data[7:0], addr[6:0], 1'b1}, shifted MSB first.
//
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-high reset
//     bus  : spi_ctrl_master_if.master
//              req_valid/req_ready/req_addr/req_data : request handshake
//              busy : frame in progress or request pending
//              done : one-cycle pulse on the first ncs-high cycle of a frame end
//              sclk/copi/ncs : SPI pins (registered)
//              fsm_state : current FSM state for debug
//
//   Optional feature macro: SPI_CTRL_FIFO_EN
//     defined   : FIFO_DEPTH-entry request FIFO, req_ready = !full
//     undefined : single holding register, ready only when IDLE and empty
// -----------------------------------------------------------------------------
module spi_ctrl_master #(
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  spi_ctrl_master_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

  if (CLK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("spi_ctrl_master: illegal parameter value");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;       // cycles spent in the current state/phase
  logic [3:0]      bit_q, bit_d;       // index of the bit currently on copi
  logic            ph_q, ph_d;         // SHIFT phase: 0 = sclk low, 1 = sclk high
  logic [15:0]     word_q, word_d;     // frame being transmitted
  logic            sclk_q, copi_q, ncs_q, done_q;
  logic            sclk_d, copi_d, ncs_d, done_d;

  logic            pending;
  logic            push;
  logic            pop;
  logic [15:0]     head_word;
  logic [15:0]     req_word;

  assign req_word = {bus.req_data, bus.req_addr, 1'b1};

`ifdef SPI_CTRL_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full;

  // Ready comes from the registered count only, so a pop in a full cycle
  // cannot raise ready in that same cycle.
  assign full          = (count_q == (AW+1)'(FIFO_DEPTH));
  assign bus.req_ready = !full;
  assign push          = bus.req_valid && !full;
  assign pending       = (count_q != '0);
  assign head_word     = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= req_word;
  end
`else
  logic        hold_valid_q;
  logic [15:0] hold_word_q;

  // Ready only in IDLE with the holding register empty, so push and pop
  // can never coincide.
  assign bus.req_ready = (state_q == ST_IDLE) && !hold_valid_q;
  assign push          = bus.req_valid && bus.req_ready;
  assign pending       = hold_valid_q;
  assign head_word     = hold_word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_word_q  <= req_word;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  // State register (outputs registered alongside so pins never glitch)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ph_q    <= 1'b0;
      word_q  <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      word_q  <= word_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          bit_d   = 4'd15;
          ph_d    = 1'b0;
          pop     = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          ph_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!ph_q) begin
            ph_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            state_d = ST_HOLD;
            ph_d    = 1'b0;
          end else begin
            ph_d  = 1'b0;
            bit_d = bit_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        // A queued request leaves straight from the last GAP cycle so
        // back-to-back frames see exactly CS_GAP ncs-high cycles.
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (pending) begin
            state_d = ST_SETUP;
            bit_d   = 4'd15;
            ph_d    = 1'b0;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign word_d = pop ? head_word : word_q;

  // Output logic: next values of the registered pins, decoded from the
  // next state so each pin changes on the same edge as the state.
  always_comb begin
    ncs_d  = 1'b1;
    sclk_d = 1'b0;
    copi_d = 1'b0;
    case (state_d)
      ST_SETUP, ST_HOLD: begin
        ncs_d  = 1'b0;
        copi_d = word_d[bit_d];
      end
      ST_SHIFT: begin
        ncs_d  = 1'b0;
        sclk_d = ph_d;
        copi_d = word_d[bit_d];
      end
      default: begin
        ncs_d = 1'b1;
      end
    endcase
    done_d = (state_q == ST_HOLD) && (state_d == ST_GAP);
  end

  assign bus.ncs       = ncs_q;
  assign bus.sclk      = sclk_q;
  assign bus.copi      = copi_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != ST_IDLE) || pending;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_spi_ctrl_master.sv
module tb_spi_ctrl_master;
  localparam int CLK_DIV    = 2;
  localparam int CS_SETUP   = 2;
  localparam int CS_HOLD    = 2;
  localparam int CS_GAP     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LOW_LEN    = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
`ifdef SPI_CTRL_FIFO_EN
  localparam int EXP_STALL  = FIFO_DEPTH + 1;
`else
  localparam int EXP_STALL  = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ctrl_master_if bus ();

  spi_ctrl_master #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
    .CS_GAP(CS_GAP), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rx_log[$];
  logic [7:0]  regs [5] = '{default: 8'h00};
  int          frames_done = 0;
  int          done_seen = 0;
  int          cur_rises = 0;
  int          last_gap = 0;
  int          cyc = 0;
  int          rise_cyc = -1;
  int          acc_cnt = 0;
  int          stall_at = -1;
  bit          in_frame = 1'b0;
  int          k = 0;
  logic [15:0] cur_word = '0;
  logic [15:0] rx = '0;
  logic        prev_sclk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pin waveform of a frame as a function of cycle k since ncs fell.
  function automatic logic exp_sclk(input int kk);
    if (kk >= CS_SETUP && kk < CS_SETUP + 32 * CLK_DIV)
      return (((kk - CS_SETUP) / CLK_DIV) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic exp_copi(input logic [15:0] w, input int kk);
    int idx;
    if (kk < CS_SETUP) idx = 15;
    else if (kk < CS_SETUP + 32 * CLK_DIV) idx = 15 - (kk - CS_SETUP) / (2 * CLK_DIV);
    else idx = 0;
    return w[idx[3:0]];
  endfunction

  // ---------------- compare process (every cycle) ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_ncs", bus.ncs, 1);
      chk("rst_sclk", bus.sclk, 0);
      chk("rst_copi", bus.copi, 0);
      chk("rst_done", bus.done, 0);
      in_frame = 1'b0;
      exp_q.delete();
      rise_cyc = -1;
      cur_rises = 0;
    end else begin
      if (bus.done) done_seen++;
      if (!in_frame && !bus.ncs) begin
        in_frame = 1'b1;
        k = 0;
        rx = '0;
        cur_rises = 0;
        prev_sclk = 1'b0;
        chk("frame_expected", exp_q.size() > 0, 1);
        cur_word = (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
        if (rise_cyc >= 0) begin
          last_gap = cyc - rise_cyc;
          chk("gap_min", last_gap >= CS_GAP, 1);
        end
      end
      if (in_frame) begin
        if (k < LOW_LEN) begin
          chk("ncs_low", bus.ncs, 0);
          chk("sclk", bus.sclk, exp_sclk(k));
          chk("copi", bus.copi, exp_copi(cur_word, k));
          chk("busy_frame", bus.busy, 1);
          chk("done_frame", bus.done, 0);
          if (bus.sclk && !prev_sclk) begin
            rx = {rx[14:0], bus.copi};
            cur_rises++;
          end
          prev_sclk = bus.sclk;
          k++;
        end else begin
          chk("ncs_len", bus.ncs, 1);
          chk("done_pulse", bus.done, 1);
          chk("busy_gap", bus.busy, 1);
          chk("rises", cur_rises, 16);
          chk("frame_word", rx, cur_word);
          // peripheral register file: write bit set and address in 0..4
          if (rx[0] && rx[7:1] <= 7'd4) regs[rx[3:1]] = rx[15:8];
          rx_log.push_back(rx);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          frames_done++;
          in_frame = 1'b0;
          rise_cyc = cyc;
        end
      end else begin
        chk("idle_sclk", bus.sclk, 0);
        chk("idle_copi", bus.copi, 0);
        chk("idle_done", bus.done, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_valid = 1'b1;
    if (!bus.req_ready && stall_at < 0) stall_at = acc_cnt;
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("accept", bus.req_ready, 1);
    if (bus.req_ready) begin
      exp_q.push_back({d, a, 1'b1});
      acc_cnt++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", frames_done >= target, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("busy_idle", bus.busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          base;
    int          d0;
    int          f0;
    logic [7:0]  snap [5];
    logic [15:0] w;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ncs", bus.ncs, 1);
      chk("idle_sclk0", bus.sclk, 0);
      chk("idle_copi0", bus.copi, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_ready", bus.req_ready, 1);
    end

    // Single write 0x04 <- 0xA5
    d0 = done_seen;
    send(7'h04, 8'hA5);
    wait_frames(1);
    wait_idle();
    w = rx_log[rx_log.size() - 1];
    chk("t2_word", w, 16'hA509);
    chk("t2_done", done_seen - d0, 1);
    chk("t2_duty", regs[4], 8'hA5);

    // Back-to-back writes
    base = frames_done;
    d0 = done_seen;
    send(7'h00, 8'hFF);
    send(7'h03, 8'h0F);
    wait_frames(base + 2);
    wait_idle();
    w = rx_log[rx_log.size() - 2];
    chk("t3_word0", w, 16'hFF01);
    w = rx_log[rx_log.size() - 1];
    chk("t3_word1", w, 16'h0F07);
    chk("t3_done", done_seen - d0, 2);
    chk("t3_reg0", regs[0], 8'hFF);
    chk("t3_reg3", regs[3], 8'h0F);
`ifdef SPI_CTRL_FIFO_EN
    chk("t3_gap", last_gap, CS_GAP);
`endif

    // Out-of-range address
    for (int i = 0; i < 5; i++) snap[i] = regs[i];
    base = frames_done;
    send(7'h10, 8'h3C);
    wait_frames(base + 1);
    wait_idle();
    w = rx_log[rx_log.size() - 1];
    chk("t4_word", w, 16'h3C21);
    for (int i = 0; i < 5; i++) chk("t4_regs", regs[i], snap[i]);

    // Reset at the 8th sclk rise
    base = frames_done;
    d0 = done_seen;
    send(7'h02, 8'h55);
    begin
      int n = 0;
      while (!(in_frame && cur_rises >= 8) && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("t5_reach8", cur_rises >= 8, 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("t5_ncs", bus.ncs, 1);
    chk("t5_sclk", bus.sclk, 0);
    chk("t5_done", bus.done, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    f0 = frames_done;
    chk("t5_noframe", f0, base);
    repeat (5) @(negedge clk);
    chk("t5_nodone", done_seen - d0, 0);
    send(7'h01, 8'h66);
    wait_frames(f0 + 1);
    wait_idle();
    w = rx_log[rx_log.size() - 1];
    chk("t5_word", w, 16'h6603);
    chk("t5_reg1", regs[1], 8'h66);
    chk("t5_reg2", regs[2], 8'h00);

    // Six requests with valid held high
    base = frames_done;
    stall_at = -1;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++)
      send(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
    chk("t6_stall_at", stall_at, EXP_STALL);
    wait_frames(base + 6);
    wait_idle();

    // Random traffic with random idle spacing
    base = frames_done;
    for (int i = 0; i < 10; i++) begin
      send(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 80)) @(negedge clk);
    end
    wait_frames(base + 10);
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
